// File: rtl/instruction_encoder_loader.sv
// Packs decoded RV32I fields plus a full immediate into instruction words
// and streams them to instruction memory at consecutive word addresses.
module instruction_encoder_loader #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_imm_src,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [8:0]        word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc;
    logic              legal;
    logic              shift_op;
    logic              accept;
    logic              full;
    logic              take;
    logic              restart;

    // Low address bits are forced to zero on session start.
    logic unused_ok;
    assign unused_ok = ^base_addr[1:0];

    // Sign-extension checks: every bit above the field's sign bit must match it.
    logic fit12, fit13, fit21;
    assign fit12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign fit13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign fit21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

    assign shift_op = (in_opcode == 7'b0010011)
                   && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    always_comb begin
        enc   = '0;
        legal = 1'b0;
        unique case (in_imm_src)
            3'b000: begin
                if (shift_op) begin
                    enc   = {in_funct7, in_imm[4:0], in_rs1,
                             in_funct3, in_rd, in_opcode};
                    legal = (in_imm[31:5] == '0);
                end else begin
                    enc   = {in_imm[11:0], in_rs1,
                             in_funct3, in_rd, in_opcode};
                    legal = fit12;
                end
            end
            3'b001: begin
                enc   = {in_imm[11:5], in_rs2, in_rs1,
                         in_funct3, in_imm[4:0], in_opcode};
                legal = fit12;
            end
            3'b010: begin
                enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                         in_funct3, in_imm[4:1], in_imm[11], in_opcode};
                legal = fit13 && !in_imm[0];
            end
            3'b011: begin
                enc   = {in_imm[20], in_imm[10:1], in_imm[11],
                         in_imm[19:12], in_rd, in_opcode};
                legal = fit21 && !in_imm[0];
            end
            3'b100: begin
                enc   = {in_imm[31:12], in_rd, in_opcode};
                legal = (in_imm[11:0] == '0);
            end
            3'b101: begin
                enc   = {in_funct7, in_rs2, in_rs1,
                         in_funct3, in_rd, in_opcode};
                legal = 1'b1;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign full     = (word_count == 9'(MAX_WORDS));
    assign take     = accept && legal && !full;
    assign restart  = start && (state != LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (accept && (!take || in_last)) state_nx = DONE;
            end
            DONE: begin
                if (start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            word_count <= '0;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                addr       <= {base_addr[ADDR_W-1:2], 2'b00};
                word_count <= '0;
                error      <= 1'b0;
            end else if (take) begin
                mem_we     <= 1'b1;
                mem_addr   <= addr;
                mem_wdata  <= enc;
                addr       <= addr + ADDR_W'(4);
                word_count <= word_count + 9'd1;
            end else if (accept) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Bench for instruction_encoder_loader: constant vectors, directed
// sequences and random sessions against a field-level reference model.
module tb_instruction_encoder_loader;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_src;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    instruction_encoder_loader #(.ADDR_W(32), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_src(in_imm_src), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } b_t;

    typedef struct {
        b_t          b;
        logic [31:0] exp_w;
        logic        exp_ok;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    bit          m_load;
    bit          m_done;
    bit          m_err;
    logic [31:0] m_addr;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm);
        chk({nm, ".busy"}, 32'(busy), 32'(m_load));
        chk({nm, ".ready"}, 32'(in_ready), 32'(m_load));
        chk({nm, ".done"}, 32'(done), 32'(m_done));
        chk({nm, ".error"}, 32'(error), 32'(m_err));
        chk({nm, ".count"}, 32'(word_count), 32'(m_cnt));
    endtask

    function automatic b_t mk(input logic [2:0] src, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
        b_t b;
        b.src = src; b.op = op; b.f3 = f3; b.f7 = f7;
        b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        return b;
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] v, input int pos);
        return v << pos;
    endfunction

    // Reference encoder: legality from signed integer ranges, bits by masks.
    function automatic void ref_enc(input b_t b, output logic ok,
                                    output logic [31:0] w);
        longint s;
        logic [31:0] u;
        s = longint'($signed(b.imm));
        u = b.imm;
        w = 32'(b.op);
        ok = 1'b0;
        case (b.src)
            3'd0: begin
                w |= fld(32'(b.rd), 7) | fld(32'(b.f3), 12) | fld(32'(b.rs1), 15);
                if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
                    ok = (s >= 0) && (s <= 31);
                    w |= fld(u & 31, 20) | fld(32'(b.f7), 25);
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    w |= fld(u & 32'hFFF, 20);
                end
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w |= fld(u & 31, 7) | fld(32'(b.f3), 12) | fld(32'(b.rs1), 15)
                   | fld(32'(b.rs2), 20) | fld((u >> 5) & 127, 25);
            end
            3'd2: begin
                ok = (s % 2 == 0) && (s >= -4096) && (s <= 4094);
                w |= fld((u >> 11) & 1, 7) | fld((u >> 1) & 15, 8)
                   | fld(32'(b.f3), 12) | fld(32'(b.rs1), 15)
                   | fld(32'(b.rs2), 20) | fld((u >> 5) & 63, 25)
                   | fld((u >> 12) & 1, 31);
            end
            3'd3: begin
                ok = (s % 2 == 0) && (s >= -1048576) && (s <= 1048574);
                w |= fld(32'(b.rd), 7) | fld((u >> 12) & 255, 12)
                   | fld((u >> 11) & 1, 20) | fld((u >> 1) & 1023, 21)
                   | fld((u >> 20) & 1, 31);
            end
            3'd4: begin
                ok = (u % 4096) == 0;
                w |= fld(32'(b.rd), 7) | (u & 32'hFFFFF000);
            end
            3'd5: begin
                ok = 1'b1;
                w |= fld(32'(b.rd), 7) | fld(32'(b.f3), 12) | fld(32'(b.rs1), 15)
                   | fld(32'(b.rs2), 20) | fld(32'(b.f7), 25);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        cycle();
        rst = 1'b0;
        m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_addr = '0;
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk_state("rst");
    endtask

    task automatic go(input logic [31:0] base);
        start = 1'b1;
        base_addr = base;
        in_valid = 1'b0;
        cycle();
        start = 1'b0;
        if (!m_load) begin
            m_load = 1; m_done = 0; m_err = 0; m_cnt = 0;
            m_addr = base & 32'hFFFFFFFC;
        end
        chk("start.mem_we", 32'(mem_we), 32'd0);
        chk_state("start");
    endtask

    task automatic idle();
        in_valid = 1'b0;
        start = 1'b0;
        cycle();
        chk("idle.mem_we", 32'(mem_we), 32'd0);
        chk_state("idle");
    endtask

    task automatic send(input b_t b, input bit last, input bit st,
                        output logic got_we, output logic [31:0] got_w);
        logic ok;
        logic [31:0] w;
        logic [31:0] exp_a;
        bit exp_we;
        in_imm_src = b.src; in_opcode = b.op; in_funct3 = b.f3;
        in_funct7 = b.f7; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_imm = b.imm; in_last = last; in_valid = 1'b1; start = st;
        ref_enc(b, ok, w);
        cycle();
        exp_we = 0;
        exp_a = m_addr;
        if (m_load) begin
            if (ok && m_cnt < MW) begin
                exp_we = 1;
                m_addr += 4;
                m_cnt++;
                if (last) begin m_load = 0; m_done = 1; end
            end else begin
                m_err = 1; m_load = 0; m_done = 1;
            end
        end
        chk("send.mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            chk("send.addr", mem_addr, exp_a);
            chk("send.wdata", mem_wdata, w);
        end
        chk_state("send");
        got_we = mem_we;
        got_w = mem_wdata;
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    function automatic b_t rand_b();
        b_t b;
        b.src = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                             : 3'($urandom_range(0, 5));
        b.op  = 7'($urandom_range(0, 127));
        b.f3  = 3'($urandom_range(0, 7));
        if (b.src == 3'd0 && $urandom_range(0, 1) == 1) b.op = 7'h13;
        b.f7  = 7'($urandom_range(0, 127));
        b.rd  = 5'($urandom_range(0, 31));
        b.rs1 = 5'($urandom_range(0, 31));
        b.rs2 = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0: b.imm = $urandom;
            1: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: b.imm = $urandom & 32'hFFFFF000;
            default: b.imm = 32'($urandom_range(0, 40));
        endcase
        return b;
    endfunction

    vec_t        tbl[16];
    logic        we;
    logic [31:0] wd;
    b_t          good;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_imm_src = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;

        tbl[0]  = '{mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -4), 32'hFE000EE3, 1'b1};
        tbl[1]  = '{mk(3'd3, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 2048), 32'h001000EF, 1'b1};
        tbl[2]  = '{mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000), 32'h123452B7, 1'b1};
        tbl[3]  = '{mk(3'd0, 7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 4), 32'h4041D193, 1'b1};
        tbl[4]  = '{mk(3'd5, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 0), 32'h002081B3, 1'b1};
        tbl[5]  = '{mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -2048), 32'h80000093, 1'b1};
        tbl[6]  = '{mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4094), 32'h7E000FE3, 1'b1};
        tbl[7]  = '{mk(3'd3, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -1048576), 32'h8000006F, 1'b1};
        tbl[8]  = '{mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001), 32'h0, 1'b0};
        tbl[9]  = '{mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 2048), 32'h0, 1'b0};
        tbl[10] = '{mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3), 32'h0, 1'b0};
        tbl[11] = '{mk(3'd0, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32), 32'h0, 1'b0};
        tbl[12] = '{mk(3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 0), 32'h0, 1'b0};
        tbl[13] = '{mk(3'd3, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 1048576), 32'h0, 1'b0};
        tbl[14] = '{mk(3'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, -2049), 32'h0, 1'b0};
        tbl[15] = '{mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4096), 32'h0, 1'b0};

        cycle();
        do_rst();
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);

        // First program: base low bits must be dropped.
        go(32'h102);
        send(mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 5), 1'b0, 1'b0, we, wd);
        chk("addi.word", wd, 32'h00500093);
        chk("addi.addr", mem_addr, 32'h100);
        send(mk(3'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 8), 1'b1, 1'b0, we, wd);
        chk("sw.word", wd, 32'h0020A423);
        chk("sw.addr", mem_addr, 32'h104);
        chk("prog.count", 32'(word_count), 32'd2);
        chk("prog.done", 32'(done), 32'd1);
        chk("prog.error", 32'(error), 32'd0);
        idle();

        for (int i = 0; i < 16; i++) begin
            go(32'h1000 + 32'(i) * 16);
            send(tbl[i].b, 1'b1, 1'b0, we, wd);
            chk($sformatf("tbl%0d.we", i), 32'(we), 32'(tbl[i].exp_ok));
            if (tbl[i].exp_ok) chk($sformatf("tbl%0d.word", i), wd, tbl[i].exp_w);
            chk($sformatf("tbl%0d.error", i), 32'(error), 32'(!tbl[i].exp_ok));
        end
        go(32'h0);
        chk("restart.error", 32'(error), 32'd0);

        // Back-to-back bundles write on consecutive cycles.
        send(tbl[0].b, 1'b0, 1'b0, we, wd);
        send(tbl[1].b, 1'b0, 1'b0, we, wd);
        chk("b2b.we", 32'(we), 32'd1);
        chk("b2b.addr", mem_addr, 32'h4);
        send(tbl[2].b, 1'b1, 1'b0, we, wd);
        chk("b2b.last_we", 32'(we), 32'd1);
        idle();

        // Overflow: fifth bundle rejected with no write.
        good = tbl[4].b;
        go(32'h800);
        for (int i = 0; i < 5; i++) send(good, 1'b0, 1'b0, we, wd);
        chk("ovf.we", 32'(we), 32'd0);
        chk("ovf.count", 32'(word_count), 32'd4);
        chk("ovf.error", 32'(error), 32'd1);

        // in_valid while DONE is ignored.
        send(good, 1'b0, 1'b0, we, wd);
        chk("done_valid.we", 32'(we), 32'd0);

        // start during LOAD is ignored.
        go(32'h300);
        send(good, 1'b0, 1'b0, we, wd);
        send(good, 1'b0, 1'b1, we, wd);
        chk("start_in_load.addr", mem_addr, 32'h304);

        // Reset while a write is pending.
        send(good, 1'b0, 1'b0, we, wd);
        do_rst();
        chk("rst_mid.count", 32'(word_count), 32'd0);

        for (int s = 0; s < 40; s++) begin
            go($urandom);
            for (int k = 0; k < 10 && m_load; k++) begin
                if ($urandom_range(0, 3) == 0) idle();
                send(rand_b(), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0, we, wd);
            end
            idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
